// File: rtl/hazard_scoreboard.sv
// Counter-based RAW hazard scheduler for the ID stage of a 5-stage RISC-V pipeline.
// Each architectural register has a down-counter holding the number of cycles until
// an in-flight write becomes readable; a taken branch costs one wrong-path FLUSH cycle.
module hazard_scoreboard #(
  parameter int unsigned WB_LATENCY = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inst_valid,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        branch_taken,
  output logic        pc_enable,
  output logic        if_id_enable,
  output logic        stall_pipeline,
  output logic        if_id_flush,
  output logic [31:0] busy_mask,
  output logic [15:0] stall_count
);

  localparam int unsigned CW     = $clog2(WB_LATENCY + 1);
  localparam logic [CW-1:0] LAT  = CW'(WB_LATENCY);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_SB   = 7'b1100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  cnt [32];
  logic [31:0]    busy;
  logic           reads_rs1;
  logic           reads_rs2;
  logic           writes_rd;
  logic           effective;
  logic           hazard;
  logic           mark;

  // Decode which register fields the ID instruction actually uses.
  always_comb begin
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OP_R: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
        writes_rd = 1'b1;
      end
      OP_S, OP_SB: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
      end
      OP_LOAD: begin
        reads_rs1 = 1'b1;
        writes_rd = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // A register is busy while its counter is non-zero; x0 is never busy.
  always_comb begin
    busy = '0;
    for (int i = 1; i < 32; i++) begin
      busy[i] = (cnt[i] != '0);
    end
  end

  assign busy_mask = busy;

  // State register for the wrong-path flush sequencer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Hazard detection, pipeline control outputs and flush sequencing.
  always_comb begin
    state_next     = state;
    effective      = 1'b0;
    hazard         = 1'b0;
    mark           = 1'b0;
    pc_enable      = 1'b1;
    if_id_enable   = 1'b1;
    stall_pipeline = 1'b0;
    if_id_flush    = 1'b0;

    // Reset and the wrong-path slot both turn the ID instruction into a bubble.
    effective = inst_valid && (state == RUN) && !reset;
    hazard    = effective &&
                ((reads_rs1 && (rs1 != 5'd0) && busy[rs1]) ||
                 (reads_rs2 && (rs2 != 5'd0) && busy[rs2]));
    mark      = effective && !hazard && writes_rd && (rd != 5'd0);

    stall_pipeline = hazard;
    pc_enable      = !hazard;
    if_id_enable   = !hazard;
    // Branch operands are stale while stalled, so a taken result only counts on issue.
    if_id_flush    = branch_taken && effective && !hazard;

    case (state)
      RUN:     if (if_id_flush) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Per-register write-back countdown; a new mark overrides the decrement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < 32; i++) begin
        if (mark && (rd == 5'(i))) begin
          cnt[i] <= LAT;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CW'(1);
        end
      end
    end
  end

  // Saturating count of bubble-inserting cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= 16'd0;
    end else if (stall_pipeline && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a timestamp-based reference model.
module tb_hazard_scoreboard;

  localparam int unsigned W = 3;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_SB  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic        clock;
  logic        reset;
  logic        inst_valid;
  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        branch_taken;
  logic        pc_enable;
  logic        if_id_enable;
  logic        stall_pipeline;
  logic        if_id_flush;
  logic [31:0] busy_mask;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(.WB_LATENCY(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .inst_valid     (inst_valid),
    .opcode         (opcode),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd             (rd),
    .branch_taken   (branch_taken),
    .pc_enable      (pc_enable),
    .if_id_enable   (if_id_enable),
    .stall_pipeline (stall_pipeline),
    .if_id_flush    (if_id_flush),
    .busy_mask      (busy_mask),
    .stall_count    (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: cycle at which each register becomes readable, and the
  // single cycle (if any) whose ID instruction is on the wrong path.
  longint cyc      = 0;
  longint avail [32];
  longint flush_at = -1;
  int     stalls   = 0;

  function automatic logic m_reads1(input logic [6:0] op);
    return (op == OP_R) || (op == OP_S) || (op == OP_SB) || (op == OP_LD);
  endfunction

  function automatic logic m_reads2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_S) || (op == OP_SB);
  endfunction

  function automatic logic m_writes(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LD);
  endfunction

  function automatic logic m_busy(input logic [4:0] r);
    return (r != 5'd0) && (cyc < avail[r]);
  endfunction

  function automatic logic m_eff();
    return inst_valid && !reset && (cyc != flush_at);
  endfunction

  function automatic logic m_haz();
    return m_eff() && ((m_reads1(opcode) && m_busy(rs1)) ||
                       (m_reads2(opcode) && m_busy(rs2)));
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    m = '0;
    for (int r = 1; r < 32; r++) m[r] = m_busy(5'(r));
    return reset ? 32'd0 : m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model on every rising edge using the inputs held over that cycle.
  always @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) avail[r] = 0;
      flush_at = -1;
      stalls   = 0;
    end else begin
      logic h;
      h = m_haz();
      if (h) stalls++;
      if (m_eff() && !h && m_writes(opcode) && (rd != 5'd0)) avail[rd] = cyc + 1 + longint'(W);
      if (m_eff() && !h && branch_taken) flush_at = cyc + 1;
    end
    cyc++;
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clock) begin
    logic h;
    h = m_haz();
    chk("m_stall", 32'(stall_pipeline), 32'(h));
    chk("m_pc_en", 32'(pc_enable), 32'(!h));
    chk("m_ifid_en", 32'(if_id_enable), 32'(!h));
    chk("m_flush", 32'(if_id_flush), 32'(branch_taken && m_eff() && !h));
    chk("m_busy", busy_mask, m_mask());
    chk("m_scount", 32'(stall_count), reset ? 32'd0 : 32'((stalls > 65535) ? 65535 : stalls));
  end

  task automatic drv(input logic v, input logic [6:0] op, input logic [4:0] a,
                     input logic [4:0] b, input logic [4:0] d, input logic bt);
    inst_valid   = v;
    opcode       = op;
    rs1          = a;
    rs2          = b;
    rd           = d;
    branch_taken = bt;
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (n) nxt();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    drv(1'b1, OP_SB, 5'd1, 5'd2, 5'd0, 1'b1);
    @(posedge clock);
    @(posedge clock);
    #2;
    // reset values, with a taken branch on the inputs
    chk("rst_pc", 32'(pc_enable), 32'd1);
    chk("rst_stall", 32'(stall_pipeline), 32'd0);
    chk("rst_flush", 32'(if_id_flush), 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_cnt", 32'(stall_count), 32'd0);
    drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    reset = 1'b0;
    nxt();

    // RAW: add x5 then add x6,x5,x1 -> three stall cycles
    drv(1'b1, OP_R, 5'd1, 5'd2, 5'd5, 1'b0); #1;
    chk("raw_w_stall", 32'(stall_pipeline), 32'd0);
    nxt();
    drv(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("raw_stall", 32'(stall_pipeline), 32'd1);
      chk("raw_pc", 32'(pc_enable), 32'd0);
      chk("raw_busy5", 32'(busy_mask[5]), 32'd1);
      nxt();
    end
    #1;
    chk("raw_issue", 32'(stall_pipeline), 32'd0);
    chk("raw_cnt", 32'(stall_count), 32'd3);
    nxt();
    idle(8);

    // x0 never hazards; lui reads nothing
    drv(1'b1, OP_R, 5'd1, 5'd2, 5'd0, 1'b0); #1;
    chk("x0_w", 32'(stall_pipeline), 32'd0);
    nxt();
    drv(1'b1, OP_R, 5'd0, 5'd0, 5'd1, 1'b0); #1;
    chk("x0_r_stall", 32'(stall_pipeline), 32'd0);
    chk("x0_busy", busy_mask, 32'd0);
    nxt();
    drv(1'b1, OP_R, 5'd2, 5'd3, 5'd5, 1'b0); nxt();
    drv(1'b1, OP_LUI, 5'd5, 5'd5, 5'd5, 1'b0); #1;
    chk("lui_stall", 32'(stall_pipeline), 32'd0);
    nxt();
    idle(8);

    // load then store using x7 as rs2 two cycles later
    drv(1'b1, OP_LD, 5'd1, 5'd0, 5'd7, 1'b0); nxt();
    idle(1);
    drv(1'b1, OP_S, 5'd1, 5'd7, 5'd0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("ls_stall", 32'(stall_pipeline), 32'd1);
      nxt();
    end
    #1;
    chk("ls_issue", 32'(stall_pipeline), 32'd0);
    chk("ls_cnt", 32'(stall_count), 32'd5);
    nxt();
    idle(8);

    // taken branch: wrong-path add is ignored, RUN afterwards
    drv(1'b1, OP_R, 5'd1, 5'd2, 5'd5, 1'b0); nxt();
    drv(1'b1, OP_SB, 5'd1, 5'd2, 5'd0, 1'b1); #1;
    chk("br_flush", 32'(if_id_flush), 32'd1);
    chk("br_stall", 32'(stall_pipeline), 32'd0);
    nxt();
    drv(1'b1, OP_R, 5'd5, 5'd5, 5'd3, 1'b0); #1;
    chk("fl_stall", 32'(stall_pipeline), 32'd0);
    chk("fl_pc", 32'(pc_enable), 32'd1);
    nxt();
    #1;
    chk("fl_nomark", 32'(busy_mask[3]), 32'd0);
    chk("run_stall", 32'(stall_pipeline), 32'd1);
    nxt();
    #1;
    chk("run_issue", 32'(stall_pipeline), 32'd0);
    nxt();
    idle(8);

    // branch dependent on pending x5: flush held off until unstalled
    drv(1'b1, OP_R, 5'd1, 5'd2, 5'd5, 1'b0); nxt();
    drv(1'b1, OP_SB, 5'd5, 5'd1, 5'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bs_flush", 32'(if_id_flush), 32'd0);
      chk("bs_stall", 32'(stall_pipeline), 32'd1);
      nxt();
    end
    #1;
    chk("bs_go", 32'(if_id_flush), 32'd1);
    nxt();
    idle(8);
    chk("bs_cnt", 32'(stall_count), 32'd9);

    // reset asserted mid-stall
    drv(1'b1, OP_R, 5'd1, 5'd2, 5'd5, 1'b0); nxt();
    drv(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b0); #1;
    chk("mr_pre_busy", busy_mask, 32'h20);
    chk("mr_pre_stall", 32'(stall_pipeline), 32'd1);
    reset = 1'b1; #1;
    chk("mr_busy", busy_mask, 32'd0);
    chk("mr_stall", 32'(stall_pipeline), 32'd0);
    chk("mr_pc", 32'(pc_enable), 32'd1);
    chk("mr_cnt", 32'(stall_count), 32'd0);
    nxt();
    nxt();
    drv(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    reset = 1'b0;
    nxt();
    drv(1'b1, OP_SB, 5'd1, 5'd2, 5'd0, 1'b1); #1;
    chk("mr_run", 32'(if_id_flush), 32'd1);
    nxt();
    #1;
    chk("mr_flush_ign", 32'(if_id_flush), 32'd0);
    nxt();
    idle(4);

    // saturation: self-dependent writer keeps stalling
    drv(1'b1, OP_R, 5'd5, 5'd1, 5'd5, 1'b0);
    n = 0;
    while ((stall_count != 16'hFFFE) && (n < 90000)) begin
      nxt();
      n++;
    end
    chk("sat_reach", 32'(stall_count), 32'h0000FFFE);
    repeat (8) nxt();
    chk("sat_hold", 32'(stall_count), 32'h0000FFFF);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
